// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit: op codes, FSM states, default width.
// Latency: not applicable (package only).
// Backpressure: not applicable (package only).
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // RV32M funct3 encodings
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // All divide/remainder ops share funct3[2] = 1
  function automatic logic is_div_op(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_sign_adjust.sv
// Combinational sign handling: operand magnitudes on accept, result sign correction on completion.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the FSM in muldiv_unit decides when outputs are sampled. Macro MULDIV_DIV_EN enables div/rem results.
module muldiv_sign_adjust
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_a_mag,
  output logic [WIDTH-1:0] o_b_mag,
  output logic             o_neg_main,
`ifdef MULDIV_DIV_EN
  output logic             o_neg_rem,
  input  logic             i_fin_neg_rem,
`endif
  input  logic [2:0]       i_fin_op,
  input  logic             i_fin_neg_main,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  output logic [WIDTH-1:0] o_result
);

  logic               w_a_signed;
  logic               w_b_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic               w_div_by_zero;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_adj;

  // MULHSU treats only operand A as signed; the unsigned ops treat neither as signed
  assign w_a_signed = (i_op == OP_MUL) || (i_op == OP_MULH) || (i_op == OP_MULHSU) ||
                      (i_op == OP_DIV) || (i_op == OP_REM);
  assign w_b_signed = (i_op == OP_MUL) || (i_op == OP_MULH) ||
                      (i_op == OP_DIV) || (i_op == OP_REM);
  assign w_a_neg    = w_a_signed && i_a[WIDTH-1];
  assign w_b_neg    = w_b_signed && i_b[WIDTH-1];
  assign w_div_by_zero = is_div_op(i_op) && (i_b == '0);

  assign o_a_mag    = w_a_neg ? -i_a : i_a;
  assign o_b_mag    = w_b_neg ? -i_b : i_b;
  // Quotient of a divide-by-zero must stay all-ones regardless of dividend sign
  assign o_neg_main = (w_a_neg ^ w_b_neg) && !w_div_by_zero;
`ifdef MULDIV_DIV_EN
  assign o_neg_rem  = w_a_neg;
`endif

  assign w_prod     = {i_hi, i_lo};
  assign w_prod_adj = i_fin_neg_main ? -w_prod : w_prod;

  // Select and sign-correct the final result for the captured op
  always_comb begin
    o_result = '0;
    case (i_fin_op)
      OP_MUL:                       o_result = w_prod_adj[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: o_result = w_prod_adj[2*WIDTH-1:WIDTH];
`ifdef MULDIV_DIV_EN
      OP_DIV, OP_DIVU:              o_result = i_fin_neg_main ? -i_lo : i_lo;
      OP_REM, OP_REMU:              o_result = i_fin_neg_rem  ? -i_hi : i_hi;
`endif
      default:                      o_result = '0;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide, one bit per cycle (MULDIV_DIV_EN adds divider).
// Latency: done pulses WIDTH+1 cycles after the accept edge for every op, including divide-by-zero and overflow.
// Backpressure: start is sampled only in IDLE; requests while busy are dropped, never queued.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] RS1_data,
  input  logic [WIDTH-1:0] RS2_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] RD_data
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_opnd;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0] r_hi;     // product high half or partial remainder
  logic [WIDTH-1:0] r_lo;     // multiplier/product low half or dividend/quotient
  logic [WIDTH-1:0] r_rd;
  logic             r_busy;
  logic             r_done;
  logic             r_neg_main;

  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_neg_main;
  logic [WIDTH-1:0] w_result;
  logic [WIDTH:0]   w_add;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_lo_nxt;
`ifdef MULDIV_DIV_EN
  logic             r_neg_rem;
  logic             w_neg_rem;
  logic [WIDTH:0]   w_trial;
`endif

  assign busy    = r_busy;
  assign done    = r_done;
  assign RD_data = r_rd;

  muldiv_sign_adjust #(.WIDTH(WIDTH)) u_sign_adjust (
    .i_op           (op),
    .i_a            (RS1_data),
    .i_b            (RS2_data),
    .o_a_mag        (w_a_mag),
    .o_b_mag        (w_b_mag),
    .o_neg_main     (w_neg_main),
`ifdef MULDIV_DIV_EN
    .o_neg_rem      (w_neg_rem),
    .i_fin_neg_rem  (r_neg_rem),
`endif
    .i_fin_op       (r_op),
    .i_fin_neg_main (r_neg_main),
    .i_hi           (r_hi),
    .i_lo           (r_lo),
    .o_result       (w_result)
  );

  // One iteration step: shift-add for multiply, restoring subtract for divide
  always_comb begin
    w_add    = {1'b0, r_hi} + {1'b0, r_opnd};
    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
`ifdef MULDIV_DIV_EN
    w_trial  = {r_hi, r_lo[WIDTH-1]} - {1'b0, r_opnd};
`endif
    if (!is_div_op(r_op)) begin
      if (r_lo[0]) {w_hi_nxt, w_lo_nxt} = {w_add, r_lo[WIDTH-1:1]};
      else         {w_hi_nxt, w_lo_nxt} = {1'b0, r_hi, r_lo[WIDTH-1:1]};
    end
`ifdef MULDIV_DIV_EN
    else begin
      // Borrow out of the trial subtract means "restore": keep the shifted remainder
      if (!w_trial[WIDTH]) begin
        w_hi_nxt = w_trial[WIDTH-1:0];
        w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
      end else begin
        w_hi_nxt = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
        w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  // Control FSM plus datapath registers; RD_data only changes on the BUSY->DONE edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_op       <= OP_MUL;
      r_opnd     <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_rd       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_neg_main <= 1'b0;
`ifdef MULDIV_DIV_EN
      r_neg_rem  <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state    <= ST_BUSY;
            r_busy     <= 1'b1;
            r_op       <= op;
            r_cnt      <= '0;
            r_hi       <= '0;
            r_neg_main <= w_neg_main;
`ifdef MULDIV_DIV_EN
            r_neg_rem  <= w_neg_rem;
`endif
            if (is_div_op(op)) begin
              r_lo   <= w_a_mag;
              r_opnd <= w_b_mag;
            end else begin
              r_lo   <= w_b_mag;
              r_opnd <= w_a_mag;
            end
          end
        end
        ST_BUSY: begin
          if (r_cnt != CW'(WIDTH)) begin
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
            r_cnt <= r_cnt + 1'b1;
          end else begin
            r_rd    <= w_result;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit with hand-computed results; honours MULDIV_DIV_EN.
// Latency: checks done arrives exactly 33 cycles after each accept edge.
// Backpressure: checks that start is ignored while busy and that reset aborts an op.
module tb_muldiv_unit;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] RS1_data;
  logic [31:0] RS2_data;
  logic        busy;
  logic        done;
  logic [31:0] RD_data;

  int n_checks = 0;
  int n_errors = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .RS1_data (RS1_data),
    .RS2_data (RS2_data),
    .busy     (busy),
    .done     (done),
    .RD_data  (RD_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op, scramble operands after accept, then check latency, result and pulse width
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int cyc;
    cyc = 0;
    op = o; RS1_data = a; RS2_data = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    RS1_data = ~a; RS2_data = b ^ 32'h5A5A_A5A5; op = ~o;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        cyc = i;
        break;
      end
    end
    chk({tag, "_lat"}, 64'(cyc), 64'd33);
    chk(tag, 64'(RD_data), 64'(exp));
    @(posedge clk); #1;
    chk({tag, "_end"}, {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    int n_done;
    int first_cyc;
    logic [31:0] first_rd;

    rst = 1'b0; start = 1'b0; op = 3'b000; RS1_data = '0; RS2_data = '0;
    #3;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rd", 64'(RD_data), 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // Multiply variants
    run_op("mul_7_m3",   3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_op("mulhu_max",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("mulh_m1m1",  3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    run_op("mulh_min",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_op("mulh_m2x3",  3'b001, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF);
    run_op("mulhsu_m1",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mul_shift",  3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780);

    // Divide variants, including divide-by-zero and signed overflow
    run_op("div_m7_2",   3'b100, 32'hFFFF_FFF9, 32'd2, DIV_EN ? 32'hFFFF_FFFD : 32'd0);
    run_op("rem_m7_2",   3'b110, 32'hFFFF_FFF9, 32'd2, DIV_EN ? 32'hFFFF_FFFF : 32'd0);
    run_op("divu_100_7", 3'b101, 32'd100,       32'd7, DIV_EN ? 32'd14 : 32'd0);
    run_op("remu_100_7", 3'b111, 32'd100,       32'd7, DIV_EN ? 32'd2 : 32'd0);
    run_op("div_5_0",    3'b100, 32'd5,         32'd0, DIV_EN ? 32'hFFFF_FFFF : 32'd0);
    run_op("rem_5_0",    3'b110, 32'd5,         32'd0, DIV_EN ? 32'd5 : 32'd0);
    run_op("div_m5_0",   3'b100, 32'hFFFF_FFFB, 32'd0, DIV_EN ? 32'hFFFF_FFFF : 32'd0);
    run_op("rem_m5_0",   3'b110, 32'hFFFF_FFFB, 32'd0, DIV_EN ? 32'hFFFF_FFFB : 32'd0);
    run_op("divu_x_0",   3'b101, 32'hFFFF_FFFF, 32'd0, DIV_EN ? 32'hFFFF_FFFF : 32'd0);
    run_op("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, DIV_EN ? 32'h8000_0000 : 32'd0);
    run_op("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

    // Start pulses and operand changes during a running MUL 6 x 7 must be ignored
    n_done = 0; first_cyc = 0; first_rd = '0;
    op = 3'b000; RS1_data = 32'd6; RS2_data = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 45; i++) begin
      if (i == 3) begin RS1_data = 32'hFFFF_FFFF; RS2_data = 32'hFFFF_FFFF; end
      if (i == 5 || i == 20) begin op = 3'b011; start = 1'b1; end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        n_done++;
        if (n_done == 1) begin first_cyc = i; first_rd = RD_data; end
      end
    end
    chk("ign_ndone", 64'(n_done), 64'd1);
    chk("ign_lat", 64'(first_cyc), 64'd33);
    chk("ign_rd", 64'(first_rd), 64'd42);
    chk("ign_hold", 64'(RD_data), 64'd42);

    // Reset in the middle of a DIV aborts it; MUL accepted on first edge after release
    op = 3'b100; RS1_data = 32'd100; RS2_data = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_rd", 64'(RD_data), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    run_op("mul_3x4", 3'b000, 32'd3, 32'd4, 32'd12);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL take parameter WIDTH, default 32, as the operand and result width.
REQ-002 SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock shared with the register file.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  operation request, sampled only in IDLE.
REQ-006 op  input  3  RV32M funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 RS1_data  input  WIDTH  operand A (dividend or multiplicand), driven from the register file read port.
REQ-008 RS2_data  input  WIDTH  operand B (divisor or multiplier).
REQ-009 busy  output  1  high while in the BUSY or DONE state.
REQ-010 done  output  1  single-cycle completion pulse.
REQ-011 RD_data  output  WIDTH  result register, feeding the register-file write data port.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE: IDLE->BUSY on start=1; BUSY->DONE after exactly WIDTH iteration edges; DONE->IDLE on the next edge.
REQ-013 SHALL capture op, RS1_data and RS2_data on the accept edge; later operand changes SHALL NOT affect the result.
REQ-014 SHALL assert done for exactly one cycle, WIDTH+1 cycles after the accept edge (33 for WIDTH=32), for every op including special cases.
REQ-015 SHALL ignore start while in BUSY or DONE; no queuing.
REQ-016 SHALL multiply by shift-add, one bit per cycle, into a 2*WIDTH product.
REQ-017 MUL SHALL return the low WIDTH bits; MULH, MULHSU and MULHU SHALL return the high WIDTH bits with signed*signed, signed*unsigned and unsigned*unsigned semantics respectively.
REQ-018 SHALL divide by the restoring method, one quotient bit per cycle, on magnitudes.
REQ-019 Signed ops SHALL sign-correct on the BUSY->DONE edge: quotient negative when the operand signs differ, remainder taking the dividend's sign.
REQ-020 Divide by zero SHALL give quotient all-ones and remainder equal to the dividend, with normal latency.
REQ-021 Signed overflow (-2^(WIDTH-1) / -1) SHALL give quotient -2^(WIDTH-1) and remainder 0.
REQ-022 RD_data SHALL update only on the BUSY->DONE edge and hold until the next DONE.

Reset
REQ-023 rst=0 SHALL force state IDLE, busy=0, done=0, RD_data=0 and internal accumulators to 0, asynchronously.
REQ-024 Reset asserted mid-operation SHALL abort the operation, with no done pulse after release.
REQ-025 The first accept SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-026 Macro MULDIV_DIV_EN defined: SHALL include the divider and all eight ops.
REQ-027 Macro MULDIV_DIV_EN undefined: SHALL omit the divider logic; ops 1xx SHALL complete with normal latency and RD_data=0.

Structure
REQ-028 Package muldiv_pkg SHALL hold the op encoding constants, the FSM state typedef and the default WIDTH.
REQ-029 Sub-module muldiv_sign_adjust (combinational) SHALL compute operand magnitudes and apply result sign correction.
REQ-030 The FSM, counter and datapath registers SHALL remain in muldiv_unit.

Verification
REQ-031 MUL 7 x -3 -> done at cycle 33, RD_data=0xFFFFFFEB; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-032 DIV -7 / 2 -> 0xFFFFFFFD; REM -7 / 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
REQ-033 DIV 5 / 0 -> 0xFFFFFFFF; REM 5 / 0 -> 5; DIV 0x80000000 / -1 -> 0x80000000; REM 0x80000000 / -1 -> 0.
REQ-034 start pulsed at cycles 5 and 20 of a running op, with operands changed mid-op -> a single done, result from the original operands.
REQ-035 rst low at cycle 10 of a DIV -> busy=0 and RD_data=0 immediately, no done; new MUL 3 x 4 after release -> 12.
REQ-036 Build without MULDIV_DIV_EN: DIVU 100 / 7 -> done at cycle 33, RD_data=0; MUL still correct.
